// File: rtl/piso_sched_pkg.sv
// Shared types and helpers for the round-robin PISO transmit scheduler.
package piso_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1, so single-entry ranges still get a 1-bit field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module piso_rr_arbiter
  import piso_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [clog2(NREQ)-1:0] ptr_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        grant_o,
  output logic [clog2(NREQ)-1:0] idx_o,
  output logic                   any_valid_o
);

  localparam int IW = clog2(NREQ);

  // NOTE: every output gets a default before the search loop, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    int unsigned cand;
    grant_o     = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!any_valid_o && req_valid_i[cand]) begin
        any_valid_o   = 1'b1;
        idx_o         = IW'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Shares one LSB-first shift register among NREQ word producers, feeding a
// single-bit valid/ready serial link with a fixed idle gap after each frame.
module piso_tx_scheduler
  import piso_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     ser_ready,
  output logic                     ser_valid,
  output logic                     ser_out,
  output logic                     ser_first,
  output logic                     ser_last,
  output logic [clog2(NREQ)-1:0]   gnt_id,
  output logic                     busy
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(WIDTH + 1);
  localparam int GW = clog2(GAP + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [IW-1:0]    ptr_q,   ptr_d;
  logic [IW-1:0]    gnt_q,   gnt_d;
  logic [GW-1:0]    gap_q,   gap_d;

  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  piso_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .ptr_i       (ptr_q),
    .req_valid_i (req_valid),
    .grant_o     (arb_grant),
    .idx_o       (arb_idx),
    .any_valid_o (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gap_d     = gap_q;
    req_ready = '0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Masked by reset so the grant never shows while the block is held in reset.
        req_ready = arb_grant & {NREQ{rst}};
        if (arb_any) begin
          shreg_d = req_data[arb_idx*WIDTH +: WIDTH];
          gnt_d   = arb_idx;
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_first = (cnt_q == '0);
        ser_last  = (cnt_q == CW'(WIDTH - 1));
        if (ser_ready) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (ser_last) begin
            gap_d   = '0;
            state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      gap_q   <= gap_d;
    end
  end

  assign ser_out = shreg_q[0];
  assign gnt_id  = gnt_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_piso_tx_scheduler;

  localparam int N = 4;
  localparam int W = 4;
  localparam int G = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           ser_ready;
  logic           ser_valid, ser_out, ser_first, ser_last;
  logic [1:0]     gnt_id;
  logic           busy;

  // Second build: one requester, one-bit words, no gap.
  logic           v1, d1, sr1;
  logic           r1, sv1, so1, sf1, sl1, b1;
  logic [0:0]     g1;

  int checks = 0;
  int errors = 0;

  piso_tx_scheduler #(.NREQ(N), .WIDTH(W), .GAP(G)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_ready(ser_ready), .ser_valid(ser_valid),
    .ser_out(ser_out), .ser_first(ser_first), .ser_last(ser_last),
    .gnt_id(gnt_id), .busy(busy)
  );

  piso_tx_scheduler #(.NREQ(1), .WIDTH(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1),
    .req_ready(r1), .ser_ready(sr1), .ser_valid(sv1),
    .ser_out(so1), .ser_first(sf1), .ser_last(sl1),
    .gnt_id(g1), .busy(b1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  // Reference model: a frame is "word, bits sent so far", followed by a gap count.
  logic         m_active;
  logic [W-1:0] m_word;
  int           m_sent, m_gap, m_ptr, m_gnt;

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_rdy;
    logic [3:0]   exp_ser;
    logic         exp_busy;
    int           win;
    exp_rdy  = '0;
    exp_ser  = '0;
    exp_busy = 1'b0;
    win      = -1;
    if (!rst) begin
      m_active = 1'b0; m_word = '0; m_sent = 0; m_gap = 0; m_ptr = 0; m_gnt = 0;
    end else if (m_active) begin
      exp_ser  = {1'b1, m_word[m_sent], m_sent == 0, m_sent == W - 1};
      exp_busy = 1'b1;
    end else if (m_gap > 0) begin
      exp_busy = 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) exp_rdy[win] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    check("ser_bundle", {ser_valid, ser_out, ser_first, ser_last}, exp_ser);
    check("gnt_id", gnt_id, m_gnt);
    check("busy", busy, exp_busy);
    if (rst) begin
      if (m_active) begin
        if (ser_ready) begin
          m_sent++;
          if (m_sent == W) begin
            m_active = 1'b0;
            m_gap    = G;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (win >= 0) begin
        m_word   = req_data[win*W +: W];
        m_gnt    = win;
        m_ptr    = (win + 1) % N;
        m_active = 1'b1;
        m_sent   = 0;
      end
    end
  end

  initial begin
    int gq[$];
    int cq[$];
    int n, w;
    logic saw2;
    logic [3:0] bits1;
    req_valid = '0; req_data = '0; ser_ready = 1'b1;
    v1 = 1'b0; d1 = 1'b0; sr1 = 1'b1;
    #1 rst = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_gnt", gnt_id, 0);
    rst = 1'b1;

    // One-bit build: a single cycle carries first, last and the data bit.
    v1 = 1'b1; d1 = 1'b1;
    @(negedge clk); check("w1_ready", r1, 1);
    tick(); v1 = 1'b0;
    @(negedge clk); check("w1_bit", {sv1, so1, sf1, sl1}, 4'b1111);
    tick();
    @(negedge clk); check("w1_idle", {b1, sv1, g1}, 3'b000);
    tick();

    // Single word 1101 from requester 0.
    bits1 = 4'b1101;
    req_valid = 4'b0001; req_data[3:0] = 4'b1101;
    @(negedge clk); check("t1_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    for (int b = 0; b < W; b++) begin
      @(negedge clk);
      check("t1_bit", {ser_valid, ser_out, ser_first, ser_last},
            {1'b1, bits1[b], b == 0, b == W - 1});
      check("t1_gnt", gnt_id, 0);
      tick();
    end
    @(negedge clk); check("t1_gap", {busy, ser_valid}, 2'b10);
    tick();
    @(negedge clk); check("t1_idle", busy, 0);
    tick();

    // Round-robin from a fresh pointer with everyone valid.
    rst = 1'b0; tick(); rst = 1'b1;
    req_valid = 4'hF; req_data = {4'h8, 4'h4, 4'h2, 4'h1};
    for (int cyc = 0; cyc < 27; cyc++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        gq.push_back(onehot_idx(req_ready));
        cq.push_back(cyc);
      end
      tick();
    end
    req_valid = '0;
    wait_idle();
    check("rr_count", gq.size() >= 5, 1);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      check("rr_grant", gq[i], i % 4);
      if (i > 0) check("rr_period", cq[i] - cq[i-1], 6);
    end

    // Backpressure on word 0110 from requester 1 (pointer is now 1).
    req_valid = 4'b0010; req_data[7:4] = 4'b0110;
    @(negedge clk); check("bp_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    @(negedge clk); check("bp_bit0", {ser_valid, ser_out, ser_first, ser_last}, 4'b1010);
    tick(); ser_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); check("bp_hold", {ser_valid, ser_out, ser_first, ser_last}, 4'b1100);
      tick();
    end
    ser_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      tick();
      @(negedge clk);
    end
    check("bp_tail", n, 4);
    tick();

    // Reset during the second bit; req0 must restart from bit 0 with ptr back at 0.
    req_valid = 4'b0001; req_data[3:0] = 4'b0101;
    @(negedge clk); check("rs_ready", req_ready, 4'b0001);
    tick(); req_valid = 4'b1001;
    @(negedge clk); check("rs_bit0", {ser_valid, ser_out}, 2'b11);
    tick();
    rst = 1'b0;
    #1;
    check("rs_async", {ser_valid, busy, req_ready}, 6'b0);
    tick(); tick(); rst = 1'b1;
    @(negedge clk); check("rs_regrant", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk);
    check("rs_first", {ser_valid, ser_out, ser_first, ser_last}, 4'b1110);
    check("rs_gnt", gnt_id, 0);
    wait_idle();

    // Withdrawn request: req2 drops during the gap, req3 must win.
    req_valid = 4'b0001;
    tick(); req_valid = 4'b1100;
    w = -1; saw2 = 1'b0;
    for (int i = 0; i < 20 && w < 0; i++) begin
      @(negedge clk);
      if (req_ready[2]) saw2 = 1'b1;
      if (|(req_ready & req_valid)) w = onehot_idx(req_ready);
      tick();
      if (busy && !ser_valid) req_valid = 4'b1000;
    end
    req_valid = '0;
    check("wd_grant", w, 3);
    check("wd_no_rdy2", saw2, 0);
    wait_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      req_data  = (N*W)'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0; ser_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
